ahb_gpio_multi: RTL and testbench

AHB-Lite slave GPIO block with a parametrised channel count and channel width. Each channel provides:
- an output register
- a per-bit direction (output-enable) register
- a synchronised input register
- optional rising-edge interrupt logic

It replaces the fixed two-port 16-bit GPIO slave on the AHB-Lite bus. Pads and tristates sit outside it, driven by gpio_out/gpio_oe.

---
 rtl/ahb_gpio_multi.sv | 198 +++++++++++++++++++
 tb/tb_ahb_gpio_multi.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ahb_gpio_multi.sv
// AHB-Lite GPIO slave: NCH channels of W bits with out/dir/in registers.
// Optional per-bit rising-edge interrupts are enabled by defining GPIO_IRQ_EN.
module ahb_gpio_multi #(
    parameter int unsigned NCH         = 4,
    parameter int unsigned W           = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                HSEL,
    input  logic                HREADY,
    input  logic [31:0]         HADDR,
    input  logic [1:0]          HTRANS,
    input  logic                HWRITE,
    input  logic [2:0]          HSIZE,
    input  logic [31:0]         HWDATA,
    output logic [31:0]         HRDATA,
    output logic                HREADYOUT,
    input  logic [NCH*W-1:0]    gpio_in,
    output logic [NCH*W-1:0]    gpio_out,
    output logic [NCH*W-1:0]    gpio_oe,
    output logic                irq
);

    localparam int unsigned NW      = NCH * W;
    localparam logic [2:0]  OFF_OUT = 3'd0;
    localparam logic [2:0]  OFF_IN  = 3'd1;
    localparam logic [2:0]  OFF_DIR = 3'd2;
    localparam logic [2:0]  OFF_IEN = 3'd3;
    localparam logic [2:0]  OFF_IST = 3'd4;

    logic           r_valid;
    logic           r_write;
    logic [2:0]     r_size;
    logic [7:0]     r_addr;
    logic           w_accept;
    logic [2:0]     w_ch;
    logic [2:0]     w_off;
    logic           w_wr;
    logic           w_rd;
    logic [3:0]     w_lane;
    logic [31:0]    w_mask32;
    logic [W-1:0]   w_mask;
    logic [W-1:0]   w_wdata;
    logic [NCH-1:0] w_hit;
    logic [31:0]    w_rdata;
    logic [NW-1:0]  r_out;
    logic [NW-1:0]  r_dir;
    logic [NW-1:0]  r_sync [SYNC_STAGES];
    logic [NW-1:0]  w_pin;
    logic [NW-1:0]  w_ien_rd;
    logic [NW-1:0]  w_ist_rd;
    logic           w_unused;

    assign w_accept = HSEL & HTRANS[1] & HREADY;

    // Address-phase capture; held while HREADY is low
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_valid <= 1'b0;
            r_write <= 1'b0;
            r_size  <= 3'd0;
            r_addr  <= 8'd0;
        end else if (HREADY) begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_write <= HWRITE;
                r_size  <= HSIZE;
                r_addr  <= HADDR[7:0];
            end
        end
    end

    assign w_ch  = r_addr[7:5];
    assign w_off = r_addr[4:2];
    assign w_wr  = r_valid & r_write & HREADY;
    assign w_rd  = r_valid & ~r_write;

    // Byte-lane enables; any size above a word behaves as a word
    always_comb begin
        w_lane = 4'b1111;
        case (r_size)
            3'b000:  w_lane = 4'b0001 << r_addr[1:0];
            3'b001:  w_lane = r_addr[1] ? 4'b1100 : 4'b0011;
            default: w_lane = 4'b1111;
        endcase
    end

    assign w_mask32 = {{8{w_lane[3]}}, {8{w_lane[2]}}, {8{w_lane[1]}}, {8{w_lane[0]}}};
    assign w_mask   = w_mask32[W-1:0];
    assign w_wdata  = HWDATA[W-1:0];

    always_comb begin
        w_hit = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            w_hit[c] = w_wr && (w_ch == 3'(c));
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_out <= '0;
            r_dir <= '0;
        end else begin
            for (int unsigned c = 0; c < NCH; c++) begin
                if (w_hit[c] && w_off == OFF_OUT)
                    r_out[c*W +: W] <= (r_out[c*W +: W] & ~w_mask) | (w_wdata & w_mask);
                if (w_hit[c] && w_off == OFF_DIR)
                    r_dir[c*W +: W] <= (r_dir[c*W +: W] & ~w_mask) | (w_wdata & w_mask);
            end
        end
    end

    // Input synchroniser chain
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= gpio_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign w_pin = r_sync[SYNC_STAGES-1];

`ifdef GPIO_IRQ_EN
    logic [NW-1:0] r_ien;
    logic [NW-1:0] r_ist;
    logic [NW-1:0] r_dly;
    logic          r_irq;
    logic [NW-1:0] w_rise;
    logic [NW-1:0] w_clr;
    logic [NW-1:0] w_ien_nxt;

    assign w_rise = w_pin & ~r_dly;

    always_comb begin
        w_clr     = '0;
        w_ien_nxt = r_ien;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (w_hit[c] && w_off == OFF_IST)
                w_clr[c*W +: W] = w_wdata & w_mask;
            if (w_hit[c] && w_off == OFF_IEN)
                w_ien_nxt[c*W +: W] = (r_ien[c*W +: W] & ~w_mask) | (w_wdata & w_mask);
        end
    end

    // Set has priority over a same-cycle W1C
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_ien <= '0;
            r_ist <= '0;
            r_dly <= '0;
            r_irq <= 1'b0;
        end else begin
            r_dly <= w_pin;
            r_ien <= w_ien_nxt;
            r_ist <= (r_ist & ~w_clr) | (w_rise & r_ien);
            r_irq <= |(r_ist & r_ien);
        end
    end

    assign w_ien_rd = r_ien;
    assign w_ist_rd = r_ist;
    assign irq      = r_irq;
`else
    assign w_ien_rd = '0;
    assign w_ist_rd = '0;
    assign irq      = 1'b0;
`endif

    // Data-phase read mux, zero-extended to a full word
    always_comb begin
        w_rdata = 32'd0;
        if (w_rd) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                if (w_ch == 3'(c)) begin
                    case (w_off)
                        OFF_OUT: w_rdata = 32'(r_out[c*W +: W]);
                        OFF_IN:  w_rdata = 32'(w_pin[c*W +: W]);
                        OFF_DIR: w_rdata = 32'(r_dir[c*W +: W]);
                        OFF_IEN: w_rdata = 32'(w_ien_rd[c*W +: W]);
                        OFF_IST: w_rdata = 32'(w_ist_rd[c*W +: W]);
                        default: w_rdata = 32'd0;
                    endcase
                end
            end
        end
    end

    assign HRDATA    = w_rdata;
    assign HREADYOUT = 1'b1;
    assign gpio_out  = r_out;
    assign gpio_oe   = r_dir;

    assign w_unused = ^{HADDR[31:8], HTRANS[0], HWDATA, w_mask32};

endmodule

// File: tb/tb_ahb_gpio_multi.sv
// Directed bench for ahb_gpio_multi (NCH=4, W=16, SYNC_STAGES=2).
// Interrupt checks apply when GPIO_IRQ_EN is defined.
module tb_ahb_gpio_multi;

    localparam int unsigned NCH = 4;
    localparam int unsigned W   = 16;
    localparam int unsigned SS  = 2;

    logic              HCLK;
    logic              HRESETn;
    logic              HSEL;
    logic              HREADY;
    logic [31:0]       HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [31:0]       HWDATA;
    logic [31:0]       HRDATA;
    logic              HREADYOUT;
    logic [NCH*W-1:0]  gpio_in;
    logic [NCH*W-1:0]  gpio_out;
    logic [NCH*W-1:0]  gpio_oe;
    logic              irq;

    int n_checks = 0;
    int n_errors = 0;

    ahb_gpio_multi #(.NCH(NCH), .W(W), .SYNC_STAGES(SS)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    // Entered and left at posedge+1
    task automatic bus_write(input logic [7:0] a, input logic [2:0] sz, input logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = sz; HADDR = {24'h0, a};
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
        @(posedge HCLK); #1;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = 3'b010; HADDR = {24'h0, a};
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        d = HRDATA;
        @(posedge HCLK); #1;
    endtask

    logic [31:0] rd;

    initial begin
        HRESETn = 1'b0; HSEL = 1'b0; HREADY = 1'b1; HADDR = '0; HTRANS = 2'b00;
        HWRITE = 1'b0; HSIZE = 3'b010; HWDATA = '0; gpio_in = '0;
        idle(3);
        #2;
        check("rst_out",    64'(gpio_out), 64'h0);
        check("rst_oe",     64'(gpio_oe), 64'h0);
        check("rst_irq",    64'(irq), 64'h0);
        check("rst_hrdata", 64'(HRDATA), 64'h0);
        check("rst_hready", 64'(HREADYOUT), 64'h1);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        idle(2);

        // Word writes, truncated to W bits
        bus_write(8'h00, 3'b010, 32'h1a2b3c4d);
        bus_write(8'h20, 3'b010, 32'h12345678);
        bus_read(8'h20, rd);
        check("rd_ch1_word", 64'(rd), 64'h5678);
        check("out_words", 64'(gpio_out), 64'h0000_0000_5678_3c4d);

        // Partial-lane writes
        bus_write(8'h01, 3'b000, 32'h00005500);
        bus_write(8'h22, 3'b001, 32'hbeef0000);
        bus_read(8'h20, rd);
        check("half_hi_lanes_unstored", 64'(rd), 64'h5678);
        bus_write(8'h20, 3'b001, 32'h0000beef);
        bus_read(8'h00, rd);
        check("rd_ch0_byte", 64'(rd), 64'h554d);
        bus_read(8'h20, rd);
        check("rd_ch1_half", 64'(rd), 64'hbeef);
        check("out_partial", 64'(gpio_out), 64'h0000_0000_beef_554d);
        bus_write(8'h40, 3'b011, 32'hffffa5a5);
        check("size_gt_word", 64'(gpio_out), 64'h0000_a5a5_beef_554d);

        // Direction, invalid channel and reserved offsets
        bus_write(8'h08, 3'b010, 32'h000000ff);
        check("oe_after_write", 64'(gpio_oe), 64'h00ff);
        bus_read(8'h88, rd);
        check("rd_bad_ch", 64'(rd), 64'h0);
        bus_write(8'h88, 3'b010, 32'hffffffff);
        bus_write(8'h80, 3'b010, 32'hffffffff);
        check("bad_ch_out", 64'(gpio_out), 64'h0000_a5a5_beef_554d);
        check("bad_ch_oe",  64'(gpio_oe), 64'h00ff);
        bus_read(8'h08, rd);
        check("rd_dir", 64'(rd), 64'h00ff);
        bus_write(8'h14, 3'b010, 32'hffffffff);
        bus_read(8'h14, rd);
        check("rd_reserved", 64'(rd), 64'h0);
        check("hrdata_idle", 64'(HRDATA), 64'h0);

        // Input synchroniser latency
        gpio_in = 64'hdcba_0000_0000_1234;
        bus_read(8'h64, rd);
        check("in_old", 64'(rd), 64'h0);
        idle(1);
        bus_read(8'h64, rd);
        check("in_new", 64'(rd), 64'hdcba);
        bus_read(8'h04, rd);
        check("in_with_dir", 64'(rd), 64'h1234);

`ifdef GPIO_IRQ_EN
        bus_write(8'h2c, 3'b010, 32'h1);
        gpio_in[16] = 1'b1;
        idle(5);
        check("irq_set", 64'(irq), 64'h1);
        bus_read(8'h30, rd);
        check("stat_set", 64'(rd), 64'h1);
        bus_write(8'h30, 3'b010, 32'h1);
        check("irq_lag", 64'(irq), 64'h1);
        idle(1);
        check("irq_clr", 64'(irq), 64'h0);
        bus_read(8'h30, rd);
        check("stat_clr", 64'(rd), 64'h0);
        gpio_in[16] = 1'b0;
        idle(4);
        gpio_in[16] = 1'b1;
        idle(5);
        bus_read(8'h30, rd);
        check("stat_reset2", 64'(rd), 64'h1);
        gpio_in[16] = 1'b0;
        idle(4);
        gpio_in[16] = 1'b1;
        idle(1);
        bus_write(8'h30, 3'b010, 32'h1);
        bus_read(8'h30, rd);
        check("set_beats_w1c", 64'(rd), 64'h1);
        bus_write(8'h2c, 3'b010, 32'h0);
        idle(2);
        check("irq_masked", 64'(irq), 64'h0);
        bus_read(8'h30, rd);
        check("stat_kept", 64'(rd), 64'h1);
        bus_write(8'h2c, 3'b010, 32'h1);
        idle(2);
        check("irq_unmasked", 64'(irq), 64'h1);
`else
        bus_write(8'h2c, 3'b010, 32'hffff);
        bus_read(8'h2c, rd);
        check("ien_absent", 64'(rd), 64'h0);
        gpio_in[16] = 1'b1;
        idle(5);
        bus_read(8'h30, rd);
        check("stat_absent", 64'(rd), 64'h0);
        check("irq_tied", 64'(irq), 64'h0);
`endif

        // Reset during a write data phase
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'b010; HADDR = 32'h08;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'hffff;
        #2;
        HRESETn = 1'b0;
        #1;
        check("mid_rst_oe", 64'(gpio_oe), 64'h0);
        check("mid_rst_irq", 64'(irq), 64'h0);
        check("mid_rst_hrdata", 64'(HRDATA), 64'h0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        idle(1);
        bus_read(8'h08, rd);
        check("post_rst_dir", 64'(rd), 64'h0);
        check("post_rst_out", 64'(gpio_out), 64'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
